// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: RV32I opcode enum, sequencer state,
// and the per-opcode register-usage lookups used by the load-use check.
package pipe_ctrl_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic uses_rs1(input rv32i_opcode op);
        logic r;
        case (op)
            op_jalr, op_br, op_load, op_store, op_imm, op_reg: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input rv32i_opcode op);
        logic r;
        case (op)
            op_br, op_store, op_reg: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction waiting in IF/ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    output logic        lu_hazard
);

    rv32i_opcode op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        unused_bits;

    assign op  = rv32i_opcode'(id_instr[6:0]);
    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign lu_hazard = ex_is_load & id_valid & (ex_rd != 5'd0) &
                       (((ex_rd == rs1) & uses_rs1(op)) |
                        ((ex_rd == rs2) & uses_rs2(op)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: memory-miss stalls, load-use stalls, branch squash.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_br_take,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        imem_resp,
    input  logic        dmem_resp,
    output logic        imem_read,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        nop_if_id,
    output logic        nop_id_ex,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    state_t state_q, state_d;
    logic   i_got_q, i_got_d;
    logic   d_got_q, d_got_d;
    logic   d_need, i_ok, d_ok, adv;
    logic   lu_hazard;
    logic   unused_state;

    hazard_detect u_hazard_detect (
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .lu_hazard  (lu_hazard)
    );

    assign d_need = mem_read | mem_write;
    assign i_ok   = imem_resp | i_got_q;
    assign d_ok   = ~d_need | dmem_resp | d_got_q;
    assign adv    = i_ok & d_ok;
    assign unused_state = (state_q == WAIT);

    always_comb begin
        state_d = RUN;
        i_got_d = 1'b0;
        d_got_d = 1'b0;
        if (!adv) begin
            state_d = WAIT;
            i_got_d = i_got_q | imem_resp;
            d_got_d = d_got_q | (dmem_resp & d_need);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            i_got_q <= 1'b0;
            d_got_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_got_q <= i_got_d;
            d_got_q <= d_got_d;
        end
    end

    // Priority: reset, memory stall, taken branch, load-use, normal advance.
    always_comb begin
        imem_read   = ~rst & ~i_got_q;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        nop_if_id   = 1'b0;
        nop_id_ex   = 1'b0;
        if (rst) begin
            nop_if_id = 1'b1;
            nop_id_ex = 1'b1;
        end else if (adv) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (ex_br_take) begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
                nop_if_id  = 1'b1;
                nop_id_ex  = 1'b1;
            end else if (lu_hazard) begin
                nop_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'h0;
            flush_q <= 32'h0;
        end else begin
            if (!adv)
                stall_q <= stall_q + 32'd1;
            if (adv && ex_br_take)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'h0;
    assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall/squash rules.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_JAL   = 7'h6F;
    localparam logic [6:0] OPC_JALR  = 7'h67;
    localparam logic [6:0] OPC_BR    = 7'h63;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_IMM   = 7'h13;
    localparam logic [6:0] OPC_REG   = 7'h33;
    localparam logic [6:0] OPC_SYS   = 7'h73;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid, ex_is_load, ex_br_take;
    logic [4:0]  ex_rd;
    logic        mem_read, mem_write, imem_resp, dmem_resp;
    logic        imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        nop_if_id, nop_id_ex;
    logic [31:0] stall_cycles, flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    // model state
    bit          m_i_done, m_d_done;
    logic [31:0] m_stalls, m_flushes;
    logic [6:0]  op_table [10];

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_br_take   (ex_br_take),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .imem_resp    (imem_resp),
        .dmem_resp    (dmem_resp),
        .imem_read    (imem_read),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .nop_if_id    (nop_if_id),
        .nop_id_ex    (nop_id_ex),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op == OPC_JALR || op == OPC_BR || op == OPC_LOAD ||
               op == OPC_STORE || op == OPC_IMM || op == OPC_REG;
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op == OPC_BR || op == OPC_STORE || op == OPC_REG;
    endfunction

    function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, 5'd7, op};
    endfunction

    function automatic logic [31:0] exp_counter(input logic [31:0] v);
`ifdef PIPE_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Drive one cycle of inputs (called at posedge+1), check mid-cycle, update model at the edge.
    task automatic step(input logic [31:0] instr, input bit idv, input bit exl, input logic [4:0] rd,
                        input bit br, input bit mr, input bit mw, input bit ir, input bit dr);
        bit          waiting_d, fetch_ready, data_ready, go, hazard;
        logic [4:0]  e_loads;
        logic [1:0]  e_nops;
        id_instr = instr; id_valid = idv; ex_is_load = exl; ex_rd = rd;
        ex_br_take = br; mem_read = mr; mem_write = mw; imem_resp = ir; dmem_resp = dr;
        #3;
        waiting_d   = mr || mw;
        fetch_ready = ir || m_i_done;
        data_ready  = !waiting_d || dr || m_d_done;
        go          = fetch_ready && data_ready;
        hazard      = exl && idv && rd != 0 &&
                      ((rd == instr[19:15] && reads_rs1(instr[6:0])) ||
                       (rd == instr[24:20] && reads_rs2(instr[6:0])));
        if (!go)          begin e_loads = 5'b00000; e_nops = 2'b00; end
        else if (br)      begin e_loads = 5'b11111; e_nops = 2'b11; end
        else if (hazard)  begin e_loads = 5'b00111; e_nops = 2'b01; end
        else              begin e_loads = 5'b11111; e_nops = 2'b00; end

        check_val("loads", {27'h0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb},
                  {27'h0, e_loads});
        check_val("imem_read", {31'h0, imem_read}, {31'h0, !m_i_done});
        if (go)
            check_val("nops", {30'h0, nop_if_id, nop_id_ex}, {30'h0, e_nops});
        check_val("stall_cycles", stall_cycles, exp_counter(m_stalls));
        check_val("flush_count", flush_count, exp_counter(m_flushes));
        $display("[TB] t=%0t instr=%h br=%0b mr/mw=%0b%0b ir/dr=%0b%0b adv=%0b loads=%b",
                 $time, instr, br, mr, mw, ir, dr, go, e_loads);

        @(posedge clk);
        if (go) begin
            m_i_done = 0; m_d_done = 0;
            if (br) m_flushes = m_flushes + 32'd1;
        end else begin
            m_i_done = m_i_done || ir;
            m_d_done = m_d_done || (dr && waiting_d);
            m_stalls = m_stalls + 32'd1;
        end
        #1;
    endtask

    // Asynchronous reset assertion mid-cycle, held across one edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_loads", {27'h0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h0);
        check_val("rst_imem_read", {31'h0, imem_read}, 32'h0);
        check_val("rst_nops", {30'h0, nop_if_id, nop_id_ex}, 32'h3);
        check_val("rst_stall", stall_cycles, 32'h0);
        check_val("rst_flush", flush_count, 32'h0);
        $display("[TB] t=%0t reset asserted", $time);
        m_i_done = 0; m_d_done = 0; m_stalls = 0; m_flushes = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        op_table = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR,
                     OPC_LOAD, OPC_STORE, OPC_IMM, OPC_REG, OPC_SYS};
        rst = 1'b0;
        id_instr = 32'h13; id_valid = 0; ex_is_load = 0; ex_rd = 0; ex_br_take = 0;
        mem_read = 0; mem_write = 0; imem_resp = 0; dmem_resp = 0;
        do_reset();

        // back-to-back hits
        for (int i = 0; i < 4; i++)
            step(mk_instr(OPC_REG, 5'd1, 5'd2), 1, 0, 5'd0, 0, 0, 0, 1, 0);
        // instruction miss: four empty cycles then the response
        for (int i = 0; i < 4; i++)
            step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 0, 0, 0, 0);
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 0, 0, 1, 0);
        // split responses: data early, instruction late
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 0, 0);
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++)
            step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 0, 0);
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 1, 0);
        // load-use: lw x5 in EX, add x6,x5,x1 in ID; then rd = x0
        step(mk_instr(OPC_REG, 5'd5, 5'd1), 1, 1, 5'd5, 0, 0, 0, 1, 0);
        step(mk_instr(OPC_REG, 5'd0, 5'd1), 1, 1, 5'd0, 0, 0, 0, 1, 0);
        // lui never hazards, jalr via rs1, store via rs2
        step(mk_instr(OPC_LUI, 5'd5, 5'd5), 1, 1, 5'd5, 0, 0, 0, 1, 0);
        step(mk_instr(OPC_JALR, 5'd9, 5'd3), 1, 1, 5'd9, 0, 0, 0, 1, 0);
        step(mk_instr(OPC_STORE, 5'd2, 5'd9), 1, 1, 5'd9, 0, 0, 0, 1, 0);
        step(mk_instr(OPC_IMM, 5'd2, 5'd9), 1, 1, 5'd9, 0, 0, 0, 1, 0);
        // taken branch with pending load-use
        step(mk_instr(OPC_REG, 5'd5, 5'd1), 1, 1, 5'd5, 1, 0, 0, 1, 0);
        // reset while waiting on data, then a stale data response
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 1, 0);
        do_reset();
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 0, 1);
        step(mk_instr(OPC_IMM, 5'd1, 5'd0), 1, 0, 5'd0, 0, 1, 0, 1, 0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            logic [4:0] r1, r2, rd;
            op = op_table[$urandom_range(0, 9)];
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0)
                do_reset();
            step(mk_instr(op, r1, r2), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rd,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencer for the five-stage RV32I pipeline. It decides every cycle which pipeline registers and the PC may load. It tracks outstanding instruction- and data-memory responses across multi-cycle cache misses, and detects load-use hazards. On a taken branch/jump it squashes the wrong-path instructions by driving the false-NOP inputs of the decode-stage control ROM and the ID/EX register.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- id_instr  in  32  instruction word in IF/ID (opcode [6:0], rs1 [19:15], rs2 [24:20])
- id_valid  in  1  IF/ID holds a real (non-NOP) instruction
- ex_is_load  in  1  ID/EX control word has opcode op_load and is not a false NOP
- ex_rd  in  5  ID/EX destination register
- ex_br_take  in  1  EX resolved a taken branch, jal or jalr this cycle
- mem_read  in  1  EX/MEM control word read bit
- mem_write  in  1  EX/MEM control word write bit
- imem_resp  in  1  instruction cache response pulse
- dmem_resp  in  1  data cache response pulse
- imem_read  out  1  fetch request for current PC
- load_pc  out  1  PC register enable
- load_if_id  out  1  IF/ID enable
- load_id_ex  out  1  ID/EX enable
- load_ex_mem  out  1  EX/MEM enable
- load_mem_wb  out  1  MEM/WB enable
- nop_if_id  out  1  false_NOP into IF/ID on next load
- nop_id_ex  out  1  false_NOP into ID/EX on next load
- stall_cycles  out  32  cycles spent not advancing (see Configuration)
- flush_count  out  32  number of taken-branch squashes (see Configuration)

## Operation
- States: RUN, WAIT. Sticky flags i_got, d_got record responses that arrived while waiting.
- d_need = mem_read | mem_write. i_ok = imem_resp | i_got. d_ok = !d_need | dmem_resp | d_got.
- adv = i_ok & d_ok. Memory stall has highest priority.
- !adv: all load_* = 0.
  - RUN→WAIT.
  - i_got |= imem_resp; d_got |= dmem_resp & d_need.
- adv, RUN or WAIT→RUN, flags cleared. Then, in priority order:
  - ex_br_take: all load_* = 1, nop_if_id = 1, nop_id_ex = 1 (squash both younger instructions).
  - Else load-use: ex_is_load & id_valid & ex_rd != 0 & (ex_rd == rs1 & uses_rs1 | ex_rd == rs2 & uses_rs2).
    - load_pc = 0, load_if_id = 0; load_id_ex/ex_mem/mem_wb = 1; nop_id_ex = 1.
  - Else: all load_* = 1, nops 0.
- Register usage:
  - uses_rs1 for jalr, br, load, store, imm, reg.
  - uses_rs2 for br, store, reg.
  - lui, auipc, jal use neither.
- imem_read = 1 whenever not in reset and !i_got (no re-request after response captured).
- Outputs are combinational from state, flags and inputs. No added latency beyond the registered flags.

## Timing
- Reset (async assert, any state):
  - state = RUN, i_got = d_got = 0, counters = 0.
  - While rst high: all load_* = 0, imem_read = 0, nop_if_id = nop_id_ex = 1.
- Hit path: imem_resp and (no dmem op or dmem_resp) in same cycle → advance that cycle; zero stall cycles.
- Miss: advance occurs in the cycle the last outstanding response arrives (same-cycle combinational use of the pulse). The next cycle is RUN with flags clear.
- Responses in different cycles: the earlier one is latched; the later one completes the advance.
- Simultaneous branch and load-use: branch wins; the hazarding instruction is squashed anyway.
- Load-use stall lasts exactly one advancing cycle. It may coincide with a memory stall; the memory stall dominates until adv.
- Reset mid-WAIT: flags dropped; any late response after reset is ignored because i_got/d_got are 0 and imem_read restarts.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cycles increments every cycle with !adv (wraps at 2^32).
  - flush_count increments on each adv & ex_br_take.
- Not defined: both ports tied to 32'h0, counters not built.

## Structure
- Package pipe_ctrl_pkg:
  - state enum (RUN, WAIT).
  - uses_rs1/uses_rs2 functions keyed on rv32i_opcode (rv32i_types).
- Sub-module hazard_detect: combinational load-use check.
  - Inputs: id_instr, id_valid, ex_is_load, ex_rd.
  - Output: lu_hazard.

## Test plan
- Back-to-back hits, imem_resp=1 each cycle, no mem ops → all load_* = 1 every cycle; stall_cycles stays 0.
- I-miss: imem_resp arrives 4 cycles after request → load_* = 0 for 4 cycles, advance in cycle 5; stall_cycles = 4.
- Split responses: lw in MEM, dmem_resp cycle 2, imem_resp cycle 5 → single advance at cycle 5; d_got held cycles 3–5.
- Load-use: ex lw x5, id add x6,x5,x1 → load_pc = load_if_id = 0, nop_id_ex = 1 for one cycle; x0 as rd gives no stall.
- Taken beq in EX with load-use pending in ID → nop_if_id = nop_id_ex = 1, load_pc = 1; flush_count = 1.
- Assert rst while in WAIT → outputs go to reset values immediately; after release, stale dmem_resp does not cause an advance.
